// File: rtl/fixed_point_divide_seq_if.sv
// Start/busy/done handshake and operand/result bundle for fixed_point_divide_seq.
// The master side issues A/B with start and observes the result; the slave side is the divider.
interface fixed_point_divide_seq_if #(
    parameter int BITSIZE = 16
);
    logic               start;
    logic [BITSIZE-1:0] A;
    logic [BITSIZE-1:0] B;
    logic               busy;
    logic               done;
    logic [BITSIZE-1:0] C;
    logic               div_by_zero;
    logic               overflow;

    modport master (
        output start, A, B,
        input  busy, done, C, div_by_zero, overflow
    );

    modport slave (
        input  start, A, B,
        output busy, done, C, div_by_zero, overflow
    );
endinterface

// File: rtl/fixed_point_divide_seq.sv
// Sequential sign-magnitude fixed-point divider, C = A / B, Qm.FRAC format.
// The magnitude quotient comes from restoring division, one bit per clock.
// The result saturates to full-scale magnitude on overflow or a zero divisor.
// Optional macro FXD_DIV_ROUND_EN: one extra iteration yields a guard bit and
// the magnitude is rounded half-up instead of truncated (latency grows by one).
module fixed_point_divide_seq #(
    parameter int BITSIZE = 16,
    parameter int FRAC    = 11
) (
    input  logic                     clk,
    input  logic                     rst_n,
    fixed_point_divide_seq_if.slave  bus
);
    // Magnitude width, quotient width before any guard bit.
    localparam int MW = BITSIZE - 1;
    localparam int N  = MW + FRAC;
`ifdef FXD_DIV_ROUND_EN
    // One extra quotient bit below the LSB serves as the rounding guard.
    localparam int QW = N + 1;
`else
    localparam int QW = N;
`endif
    localparam int CW = $clog2(QW + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t             state_r,      state_n;
    logic               sign_r,       sign_n;
    logic [MW-1:0]      divisor_r,    divisor_n;
    logic               zero_div_r,   zero_div_n;
    logic [BITSIZE-1:0] rem_r,        rem_n;
    // Dividend bits shift out of the top while quotient bits shift in at the bottom.
    logic [QW-1:0]      dq_r,         dq_n;
    logic [CW-1:0]      cnt_r,        cnt_n;
    logic               busy_r,       busy_n;
    logic               done_r,       done_n;
    logic [BITSIZE-1:0] c_r,          c_n;
    logic               dbz_r,        dbz_n;
    logic               ovf_r,        ovf_n;

    logic [BITSIZE-1:0] rem_shift_s;
    logic [BITSIZE:0]   diff_s;
    logic               nonneg_s;

    logic [N-1:0]       int_s;
    logic               guard_s;
    logic [MW:0]        rnd_s;
    logic [MW-1:0]      res_mag_s;
    logic               res_sign_s;
    logic               res_dbz_s;
    logic               res_ovf_s;

    // Trial subtract for one restoring-division step.
    always_comb begin
        rem_shift_s = {rem_r[BITSIZE-2:0], dq_r[QW-1]};
        diff_s      = {1'b0, rem_shift_s} - {2'b00, divisor_r};
        // A bit shifted out of the remainder top means the true value exceeds any divisor.
        nonneg_s    = rem_r[BITSIZE-1] | ~diff_s[BITSIZE];
    end

    // Result formatting for the FINISH edge: rounding, saturation and sign.
    always_comb begin
        int_s = dq_r[QW-1 -: N];
`ifdef FXD_DIV_ROUND_EN
        guard_s = dq_r[0];
`else
        guard_s = 1'b0;
`endif
        rnd_s     = {1'b0, int_s[MW-1:0]} + {{MW{1'b0}}, guard_s};
        res_mag_s = rnd_s[MW-1:0];
        res_dbz_s = 1'b0;
        res_ovf_s = 1'b0;
        if (zero_div_r) begin
            res_mag_s = '1;
            res_dbz_s = 1'b1;
        end else if ((|int_s[N-1:MW]) || rnd_s[MW]) begin
            res_mag_s = '1;
            res_ovf_s = 1'b1;
        end else begin
            res_mag_s = rnd_s[MW-1:0];
        end
        // A zero magnitude never carries a negative sign.
        res_sign_s = sign_r & (|res_mag_s);
    end

    // Next-state and next-register logic of the control FSM.
    always_comb begin
        state_n    = state_r;
        sign_n     = sign_r;
        divisor_n  = divisor_r;
        zero_div_n = zero_div_r;
        rem_n      = rem_r;
        dq_n       = dq_r;
        cnt_n      = cnt_r;
        busy_n     = busy_r;
        done_n     = 1'b0;
        c_n        = c_r;
        dbz_n      = dbz_r;
        ovf_n      = ovf_r;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    sign_n     = bus.A[MW] ^ bus.B[MW];
                    divisor_n  = bus.B[MW-1:0];
                    zero_div_n = ~(|bus.B[MW-1:0]);
                    rem_n      = '0;
                    dq_n       = {bus.A[MW-1:0], {(QW-MW){1'b0}}};
                    cnt_n      = CW'(QW);
                    busy_n     = 1'b1;
                    state_n    = CALC;
                end else begin
                    state_n    = IDLE;
                end
            end
            CALC: begin
                rem_n = nonneg_s ? diff_s[BITSIZE-1:0] : rem_shift_s;
                dq_n  = {dq_r[QW-2:0], nonneg_s};
                cnt_n = cnt_r - CW'(1);
                if (cnt_r == CW'(1)) begin
                    state_n = FINISH;
                end else begin
                    state_n = CALC;
                end
            end
            FINISH: begin
                c_n     = {res_sign_s, res_mag_s};
                dbz_n   = res_dbz_s;
                ovf_n   = res_ovf_s;
                done_n  = 1'b1;
                busy_n  = 1'b0;
                state_n = IDLE;
            end
            default: begin
                busy_n  = 1'b0;
                state_n = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            sign_r     <= 1'b0;
            divisor_r  <= '0;
            zero_div_r <= 1'b0;
            rem_r      <= '0;
            dq_r       <= '0;
            cnt_r      <= '0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            c_r        <= '0;
            dbz_r      <= 1'b0;
            ovf_r      <= 1'b0;
        end else begin
            state_r    <= state_n;
            sign_r     <= sign_n;
            divisor_r  <= divisor_n;
            zero_div_r <= zero_div_n;
            rem_r      <= rem_n;
            dq_r       <= dq_n;
            cnt_r      <= cnt_n;
            busy_r     <= busy_n;
            done_r     <= done_n;
            c_r        <= c_n;
            dbz_r      <= dbz_n;
            ovf_r      <= ovf_n;
        end
    end

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.C           = c_r;
    assign bus.div_by_zero = dbz_r;
    assign bus.overflow    = ovf_r;

endmodule

// File: tb/tb_fixed_point_divide_seq.sv
// Scoreboard bench for fixed_point_divide_seq: stimulus pushes model results,
// a negedge monitor pops and compares on every done pulse and checks busy.
module tb_fixed_point_divide_seq;
    localparam int BITSIZE = 16;
    localparam int FRAC    = 11;
`ifdef FXD_DIV_ROUND_EN
    localparam int LAT   = BITSIZE + FRAC + 1;
    localparam bit ROUND = 1'b1;
`else
    localparam int LAT   = BITSIZE + FRAC;
    localparam bit ROUND = 1'b0;
`endif

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] c;
        logic        dbz;
        logic        ovf;
        int          cyc;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    bit   mon_en = 1'b0;
    exp_t sbq[$];

    fixed_point_divide_seq_if #(.BITSIZE(BITSIZE)) bus ();

    fixed_point_divide_seq #(.BITSIZE(BITSIZE), .FRAC(FRAC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: real-valued quotient scaled by 2^FRAC, then truncated or rounded half-up.
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input int acc);
        exp_t e;
        longint unsigned ma, mb, q;
        logic [14:0] mag;
        logic sgn;
        ma = 64'(a[14:0]);
        mb = 64'(b[14:0]);
        e.a = a; e.b = b; e.cyc = acc + LAT; e.dbz = 1'b0; e.ovf = 1'b0;
        sgn = a[15] ^ b[15];
        if (mb == 0) begin
            mag = 15'h7fff;
            e.dbz = 1'b1;
        end else begin
            if (ROUND) q = (((ma << (FRAC + 1)) / mb) + 1) >> 1;
            else       q = (ma << FRAC) / mb;
            if (q > 64'd32767) begin
                mag = 15'h7fff;
                e.ovf = 1'b1;
            end else begin
                mag = q[14:0];
            end
        end
        if (mag == 15'h0000) sgn = 1'b0;
        e.c = {sgn, mag};
        return e;
    endfunction

    // Issue one operation to an idle DUT; returns the accepting cycle.
    task automatic issue(input logic [15:0] a, input logic [15:0] b, output int acc);
        bus.start = 1'b1; bus.A = a; bus.B = b;
        @(posedge clk); #1;
        acc = cyc;
        sbq.push_back(model(a, b, acc));
        bus.start = 1'b0;
        bus.A = 16'($urandom);
        bus.B = 16'($urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sbq.size() != 0 && n < 3 * LAT) begin
            @(posedge clk); #1;
            n++;
        end
        if (sbq.size() != 0) begin
            total++; bad++;
            $display("FAIL timeout: %0d results still pending, want 0", sbq.size());
            sbq.delete();
        end
    endtask

    // Monitor: compare each completed result and the busy level against the scoreboard.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.done) begin
                if (sbq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL spurious_done: got done=1 with nothing pending, want done=0 (cycle %0d)", cyc);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    check($sformatf("C[%h/%h]", e.a, e.b), 32'(bus.C), 32'(e.c));
                    check($sformatf("div_by_zero[%h/%h]", e.a, e.b), 32'(bus.div_by_zero), 32'(e.dbz));
                    check($sformatf("overflow[%h/%h]", e.a, e.b), 32'(bus.overflow), 32'(e.ovf));
                    check($sformatf("latency[%h/%h]", e.a, e.b), 32'(cyc), 32'(e.cyc));
                end
            end
            check("busy", 32'(bus.busy), 32'(sbq.size() > 0));
        end
    end

    logic [15:0] da [11] = '{16'h1800, 16'h9800, 16'h9800, 16'h8000, 16'h0800, 16'h0800,
                             16'h0800, 16'h7FFF, 16'hFFFF, 16'h0000, 16'h8000};
    logic [15:0] db [11] = '{16'h0C00, 16'h0C00, 16'h8C00, 16'h0C00, 16'h1800, 16'h8000,
                             16'h0000, 16'h0001, 16'h0001, 16'h0000, 16'h8000};

    initial begin
        int acc;
        logic [15:0] a, b;
        bus.start = 1'b0; bus.A = 16'h0000; bus.B = 16'h0000;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_C", 32'(bus.C), 32'd0);
        check("reset_dbz", 32'(bus.div_by_zero), 32'd0);
        check("reset_ovf", 32'(bus.overflow), 32'd0);
        rst_n = 1'b1;
        mon_en = 1'b1;

        // Directed operands: basic, signs, truncation, zero divisor, overflow, zero dividend.
        for (int i = 0; i < 11; i++) begin
            issue(da[i], db[i], acc);
            wait_idle();
        end

        // A start pulse in the middle of CALC must be ignored.
        issue(16'h2400, 16'h0500, acc);
        repeat (5) @(posedge clk);
        #1;
        bus.start = 1'b1; bus.A = 16'h1111; bus.B = 16'h0003;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_idle();

        // start held high through done: second operation accepted once the DUT is idle.
        issue(16'h0C00, 16'h0400, acc);
        bus.start = 1'b1; bus.A = 16'h8A00; bus.B = 16'h0300;
        while (cyc < acc + LAT + 1) begin
            @(posedge clk); #1;
        end
        sbq.push_back(model(16'h8A00, 16'h0300, cyc));
        bus.start = 1'b0;
        wait_idle();

        // Reset in the tenth CALC cycle discards the operation and clears the outputs.
        issue(16'h1C00, 16'h0700, acc);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midreset_busy", 32'(bus.busy), 32'd0);
        check("midreset_done", 32'(bus.done), 32'd0);
        check("midreset_C", 32'(bus.C), 32'd0);
        check("midreset_dbz", 32'(bus.div_by_zero), 32'd0);
        check("midreset_ovf", 32'(bus.overflow), 32'd0);
        sbq.delete();
        rst_n = 1'b1;
        repeat (2 * LAT) @(posedge clk);
        #1;

        // Randomised operands biased toward small divisors, zero divisors and small dividends.
        for (int i = 0; i < 40; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            case ($urandom_range(0, 3))
                0: b = 16'($urandom);
                1: b = {b[15], 15'($urandom_range(1, 16))};
                2: b = {b[15], 15'h0000};
                default: a = {a[15], 15'($urandom_range(0, 255))};
            endcase
            issue(a, b, acc);
            wait_idle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
